deal_engine: RTL

DEAL_ENGINE -- requirements
Module: deal_engine

---
 rtl/solitaire_pkg.sv | 46 ++++
 rtl/deal_order.sv | 52 +++++
 rtl/deal_engine.sv | 106 ++++++++++
 3 files changed

// File: rtl/solitaire_pkg.sv
// Shared solitaire constants: card field layout, suit codes, rank bounds,
// pile ids and the deal FSM state type.
package solitaire_pkg;
  localparam int DECK_SIZE   = 52;
  localparam int NUM_COLS    = 7;
  localparam int STOCK_DEPTH = 24;

  typedef enum logic [1:0] {
    HEARTS   = 2'd0,
    SPADES   = 2'd1,
    DIAMONDS = 2'd2,
    CLUBS    = 2'd3
  } suit_t;

  localparam int CARD_W   = 7;
  localparam int RANK_HI  = 6;
  localparam int RANK_LO  = 3;
  localparam int SUIT_HI  = 2;
  localparam int SUIT_LO  = 1;
  localparam int FACE_BIT = 0;

  localparam logic [3:0] RANK_MIN = 4'd1;
  localparam logic [3:0] RANK_MAX = 4'd13;

  localparam logic [2:0] PILE_STOCK = 3'd0;
  localparam logic [2:0] PILE_TAB1  = 3'd1;
  localparam logic [2:0] PILE_TAB2  = 3'd2;
  localparam logic [2:0] PILE_TAB3  = 3'd3;
  localparam logic [2:0] PILE_TAB4  = 3'd4;
  localparam logic [2:0] PILE_TAB5  = 3'd5;
  localparam logic [2:0] PILE_TAB6  = 3'd6;
  localparam logic [2:0] PILE_TAB7  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PRESENT, S_DONE
  } deal_state_t;

  function automatic logic rank_ok(input logic [3:0] rank);
    return (rank >= RANK_MIN) && (rank <= RANK_MAX);
  endfunction

  // (rank-1)*4+suit; only meaningful for valid ranks (0..51)
  function automatic logic [5:0] card_id(input logic [3:0] rank, input logic [1:0] suit);
    return {rank - 4'd1, suit};
  endfunction
endpackage

// File: rtl/deal_order.sv
// Klondike deal sequencer: walks the tableau triangle round by round, then
// fills the stock, producing pile/pos/face-up for the current card.
module deal_order
  import solitaire_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [2:0] pile,
  output logic [4:0] pos,
  output logic       face_up,
  output logic       last
);
  logic [2:0] rnd;
  logic [2:0] col;
  logic [4:0] stk;
  logic       in_stock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd      <= '0;
      col      <= '0;
      stk      <= '0;
      in_stock <= 1'b0;
    end else if (clr) begin
      rnd      <= '0;
      col      <= '0;
      stk      <= '0;
      in_stock <= 1'b0;
    end else if (adv) begin
      if (in_stock) begin
        stk <= stk + 5'd1;
      end else if (col == 3'(NUM_COLS - 1)) begin
        if (rnd == 3'(NUM_COLS - 1)) begin
          in_stock <= 1'b1;
        end else begin
          // each round starts on the column that gets its face-up card
          rnd <= rnd + 3'd1;
          col <= rnd + 3'd1;
        end
      end else begin
        col <= col + 3'd1;
      end
    end
  end

  assign pile    = in_stock ? PILE_STOCK : col + 3'd1;
  assign pos     = in_stock ? stk : {2'b00, rnd};
  assign face_up = !in_stock && (col == rnd);
  assign last    = in_stock && (stk == 5'(STOCK_DEPTH - 1));
endmodule

// File: rtl/deal_engine.sv
// Deals a 52-card shuffled deck into 7 tableau columns and the stock, one
// placement per handshake, flagging invalid ranks and duplicate cards.
module deal_engine
  import solitaire_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       deck_ready,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  input  logic [6:0] rd_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_pile,
  output logic [4:0] out_pos,
  output logic [6:0] out_card,
  output logic       busy,
  output logic       done,
  output logic       err_rank,
  output logic       err_dup
);
  deal_state_t state, nxt;
  logic [5:0]  idx;
  logic [51:0] seen;
  logic        accept, xfer;
  logic [2:0]  ord_pile;
  logic [4:0]  ord_pos;
  logic        ord_fu, ord_last;
  logic [3:0]  rank;
  logic [1:0]  suit;
  logic        face_in_unused;

  assign accept = (state == S_IDLE) && start && deck_ready;
  assign xfer   = (state == S_PRESENT) && out_ready;
  assign rank   = rd_data[RANK_HI:RANK_LO];
  assign suit   = rd_data[SUIT_HI:SUIT_LO];
  assign face_in_unused = rd_data[FACE_BIT];

  deal_order u_order (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .adv     (xfer),
    .pile    (ord_pile),
    .pos     (ord_pos),
    .face_up (ord_fu),
    .last    (ord_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (accept) nxt = S_FETCH;
      S_FETCH:   nxt = S_LOAD;
      S_LOAD:    nxt = S_PRESENT;
      S_PRESENT: if (out_ready) nxt = ord_last ? S_DONE : S_FETCH;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  assign rd_en     = (state == S_FETCH);
  assign rd_addr   = idx;
  assign out_valid = (state == S_PRESENT);
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      seen     <= '0;
      err_rank <= 1'b0;
      err_dup  <= 1'b0;
      out_pile <= '0;
      out_pos  <= '0;
      out_card <= '0;
    end else begin
      if (accept) begin
        idx      <= '0;
        seen     <= '0;
        err_rank <= 1'b0;
        err_dup  <= 1'b0;
      end else if (xfer) begin
        idx <= idx + 6'd1;
      end
      if (state == S_LOAD) begin
        out_pile <= ord_pile;
        out_pos  <= ord_pos;
        out_card <= {rd_data[RANK_HI:SUIT_LO], ord_fu};
        // bad ranks are flagged but never index the seen mask
        if (!rank_ok(rank)) begin
          err_rank <= 1'b1;
        end else begin
          if (seen[card_id(rank, suit)]) err_dup <= 1'b1;
          seen[card_id(rank, suit)] <= 1'b1;
        end
      end
    end
  end
endmodule
